// File: rtl/alu_result_if.sv
// Handshake bundle between the ADD unit, the result stage and writeback.
// master = producer/consumer environment side, slave = the result stage.
interface alu_result_if #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_sum;
    logic              in_carry;
    logic              in_overflow;
    logic [DEST_W-1:0] in_dest;
    logic              in_flag_we;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [DEST_W-1:0] out_dest;

    modport master (
        output in_valid, in_sum, in_carry, in_overflow, in_dest, in_flag_we, out_ready,
        input  in_ready, out_valid, out_data, out_dest
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_overflow, in_dest, in_flag_we, out_ready,
        output in_ready, out_valid, out_data, out_dest
    );
endinterface

// File: rtl/alu_result_stage.sv
// Result stage after the 16-bit adder: 2-entry FIFO toward writeback plus NZCV flags.
// Optional ALU_STICKY_OVF_EN adds a sticky overflow bit (ovf_sticky).
module alu_result_stage #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_result_if.slave bus,
    input  logic       flags_clr,
    output logic [3:0] flags_nzcv
`ifdef ALU_STICKY_OVF_EN
    ,
    output logic       ovf_sticky
`endif
);
    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [DEST_W-1:0] dest;
    } entry_t;

    entry_t     mem [2];
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;

    // Ready comes only from the registered count, so a full FIFO blocks a push even on a pop cycle.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_data  = mem[rd_ptr].data;
    assign bus.out_dest  = mem[rd_ptr].dest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: bus.in_sum, dest: bus.in_dest};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Flags track accepted results, not retired ones; clear beats a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_nzcv <= 4'b0000;
        end else if (flags_clr) begin
            flags_nzcv <= 4'b0000;
        end else if (push && bus.in_flag_we) begin
            flags_nzcv <= {bus.in_sum[WIDTH-1], (bus.in_sum == '0), bus.in_carry, bus.in_overflow};
        end
    end

`ifdef ALU_STICKY_OVF_EN
    // Set beats clear so an overflow landing on a clear cycle is still recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (push && bus.in_overflow) begin
            ovf_sticky <= 1'b1;
        end else if (flags_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: flag vector table plus FIFO handshake sequences with a queue scoreboard.
module tb_alu_result_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flags_clr = 1'b0;
    logic [3:0] flags_nzcv;
`ifdef ALU_STICKY_OVF_EN
    logic       ovf_sticky;
    bit         msticky = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    alu_result_if #(.WIDTH(16), .DEST_W(3)) bus ();

    alu_result_stage #(.WIDTH(16), .DEST_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .flags_clr  (flags_clr),
        .flags_nzcv (flags_nzcv)
`ifdef ALU_STICKY_OVF_EN
        ,
        .ovf_sticky (ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    logic [18:0] q[$];
    int          mcount = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference FIFO: predicts ready/valid/head each cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mcount = 0;
`ifdef ALU_STICKY_OVF_EN
            msticky = 1'b0;
`endif
        end else begin
            bit do_push, do_pop;
            chk("in_ready", 32'(bus.in_ready), 32'(mcount != 2));
            chk("out_valid", 32'(bus.out_valid), 32'(mcount != 0));
            if (mcount != 0) chk("head", 32'({bus.out_data, bus.out_dest}), 32'(q[0]));
`ifdef ALU_STICKY_OVF_EN
            chk("ovf_sticky", 32'(ovf_sticky), 32'(msticky));
`endif
            do_pop  = (mcount != 0) && bus.out_ready;
            do_push = bus.in_valid && (mcount != 2);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back({bus.in_sum, bus.in_dest});
`ifdef ALU_STICKY_OVF_EN
            if (do_push && bus.in_overflow) msticky = 1'b1;
            else if (flags_clr) msticky = 1'b0;
`endif
            mcount = mcount + int'(do_push) - int'(do_pop);
        end
    end

    // Hold an offer until accepted; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic offer(input logic [15:0] s, input logic c, input logic v, input logic we,
                         input logic clr, input logic [2:0] d);
        bit acc = 1'b0;
        bus.in_sum = s; bus.in_carry = c; bus.in_overflow = v;
        bus.in_flag_we = we; bus.in_dest = d; bus.in_valid = 1'b1;
        flags_clr = clr;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("offer timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        flags_clr = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && mcount != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain", 32'(mcount), 32'd0);
    endtask

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        v;
        logic        we;
        logic        clr;
        logic [3:0]  exp_nzcv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h0006, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[1] = '{16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001};
        vecs[2] = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110};
        vecs[3] = '{16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110};
        vecs[4] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000};
        vecs[5] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010};
        vecs[6] = '{16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        vecs[7] = '{16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};

        bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_carry = 1'b0; bus.in_overflow = 1'b0;
        bus.in_dest = '0; bus.in_flag_we = 1'b0; bus.out_ready = 1'b1;

        #2;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_data", 32'(bus.out_data), 32'd0);
        chk("rst out_dest", 32'(bus.out_dest), 32'd0);
        chk("rst flags", 32'(flags_nzcv), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Flag derivation table, one accepted push per row.
        for (int i = 0; i < 8; i++) begin
            offer(vecs[i].sum, vecs[i].c, vecs[i].v, vecs[i].we, vecs[i].clr, 3'(i));
            chk($sformatf("flags row %0d", i), 32'(flags_nzcv), 32'(vecs[i].exp_nzcv));
        end
        drain();

        // Backpressure: two fill the FIFO, third is held until writeback drains.
        bus.out_ready = 1'b0;
        offer(16'h0101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        offer(16'h0202, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        chk("full in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_sum = 16'h0303; bus.in_dest = 3'd3; bus.in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("held in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        offer(16'h0303, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        drain();

        // Steady push+pop at count=1.
        bus.out_ready = 1'b0;
        offer(16'hA000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_sum = 16'hA001 + 16'(i); bus.in_dest = 3'(i + 1); bus.in_valid = 1'b1;
            @(posedge clk); #1;
            chk("pp in_ready", 32'(bus.in_ready), 32'd1);
            chk("pp out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        drain();

        // Async reset with a full FIFO and flags set.
        bus.out_ready = 1'b0;
        offer(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5);
        offer(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6);
        chk("pre-rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("pre-rst flags", 32'(flags_nzcv), 32'b1001);
        #3 rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid-rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid-rst flags", 32'(flags_nzcv), 32'd0);
`ifdef ALU_STICKY_OVF_EN
        chk("mid-rst sticky", 32'(ovf_sticky), 32'd0);
`endif
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        offer(16'h00AA, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
        chk("post-rst flags", 32'(flags_nzcv), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
